fft_seq_ctrl: RTL and testbench

FFT_SEQ_CTRL -- requirements
Module: fft_seq_ctrl

---
 rtl/fft_seq_ctrl.sv | 161 ++++++++++++++++
 tb/tb_fft_seq_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_seq_ctrl.sv
// fft_seq_ctrl: control sequencer for a 32-point, 5-stage radix-2 SDF DIF FFT.
// Tracks sample validity through the pipeline, decodes per-stage butterfly and
// twiddle controls, counts output samples and supervises frame framing.
// Optional feature: define FFT_SEQ_CTRL_BITREV_EN to drive out_idx with the
// bit-reversed output count; without it out_idx is tied to zero.
module fft_seq_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid_i,
  output logic [4:0] bf_sel,
  output logic [3:0] tw_addr1,
  output logic [3:0] tw_addr2,
  output logic [3:0] tw_addr3,
  output logic [3:0] tw_addr4,
  output logic [3:0] tw_en,
  output logic       valid_o,
  output logic [4:0] out_idx,
  output logic       frame_done,
  output logic       busy,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic        w_abort;

  logic [36:1] r_s;
  logic [36:0] w_s;
  logic [4:0]  r_c [5];
  logic [4:0]  r_inCnt;
  logic [4:0]  r_oCnt;

  logic [4:0]  w_v;
  logic [4:0]  w_d;
  logic [4:0]  w_a;
  logic [4:0]  w_cBit;

  // Position 0 of the valid history is the live input; it is masked in reset
  // so nothing derived from it can leak onto the outputs.
  assign w_s = {r_s, valid_i & rst_n};

  // Stage input taps sit at 0, 17, 26, 31, 34; the matching feedback taps sit
  // one stage delay (16, 8, 4, 2, 1) further down the history.
  assign w_v = {w_s[34], w_s[31], w_s[26], w_s[17], w_s[0]};
  assign w_d = {w_s[35], w_s[33], w_s[30], w_s[25], w_s[16]};
  assign w_a = w_v | w_d;

  // Each stage toggles its butterfly every D_k samples, so it watches bit
  // log2(D_k) of its own window counter.
  assign w_cBit = {r_c[4][0], r_c[3][1], r_c[2][2], r_c[1][3], r_c[0][4]};

  // Valid history, stage window counters and the frame counters; an abort
  // flushes all of them just like reset does.
  always_ff @(posedge clk) begin
    if (!rst_n || w_abort) begin
      r_s     <= '0;
      r_inCnt <= 5'd0;
      r_oCnt  <= 5'd0;
      for (int k = 0; k < 5; k++) begin
        r_c[k] <= 5'd0;
      end
    end else begin
      r_s <= w_s[35:0];
      for (int k = 0; k < 5; k++) begin
        r_c[k] <= w_a[k] ? r_c[k] + 5'd1 : 5'd0;
      end
      if (valid_i) begin
        r_inCnt <= r_inCnt + 5'd1;
      end
      if (w_s[36]) begin
        r_oCnt <= r_oCnt + 5'd1;
      end
    end
  end

  // Frame supervisor state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Frame supervisor next-state: a gap on a frame boundary drains the
  // pipeline, a gap mid-frame aborts it.
  always_comb begin
    w_nextState = r_state;
    w_abort     = 1'b0;
    busy        = 1'b0;
    case (r_state)
      IDLE: begin
        if (valid_i) begin
          w_nextState = RUN;
        end
      end
      RUN: begin
        busy = rst_n;
        if (!valid_i) begin
          if (r_inCnt == 5'd0) begin
            w_nextState = DRAIN;
          end else begin
            w_abort     = 1'b1;
            w_nextState = IDLE;
          end
        end
      end
      DRAIN: begin
        busy = rst_n;
        if (valid_i) begin
          w_nextState = RUN;
        end else if (w_s[36:1] == 36'd0) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  assign err        = w_abort & rst_n;
  assign bf_sel     = w_a & w_cBit & {5{rst_n}};
  assign tw_en      = w_d[3:0] & ~w_cBit[3:0] & {4{rst_n}};
  assign valid_o    = w_s[36] & rst_n;
  assign frame_done = valid_o & (r_oCnt == 5'd31);

  // Twiddle index is the position within the stage's feedback window, scaled
  // so every stage addresses the same 16-entry W32 table.
  always_comb begin
    tw_addr1 = 4'd0;
    tw_addr2 = 4'd0;
    tw_addr3 = 4'd0;
    tw_addr4 = 4'd0;
    if (tw_en[0]) begin
      tw_addr1 = r_c[0][3:0];
    end
    if (tw_en[1]) begin
      tw_addr2 = {r_c[1][2:0], 1'b0};
    end
    if (tw_en[2]) begin
      tw_addr3 = {r_c[2][1:0], 2'b00};
    end
    if (tw_en[3]) begin
      tw_addr4 = {r_c[3][0], 3'b000};
    end
  end

`ifdef FFT_SEQ_CTRL_BITREV_EN
  assign out_idx = valid_o ? {r_oCnt[0], r_oCnt[1], r_oCnt[2], r_oCnt[3], r_oCnt[4]} : 5'd0;
`else
  assign out_idx = 5'd0;
`endif

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// tb_fft_seq_ctrl: directed and randomized frames against a history-based
// reference model of the FFT sequencer.
module tb_fft_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       valid_i;
  logic [4:0] bf_sel;
  logic [3:0] tw_addr1;
  logic [3:0] tw_addr2;
  logic [3:0] tw_addr3;
  logic [3:0] tw_addr4;
  logic [3:0] tw_en;
  logic       valid_o;
  logic [4:0] out_idx;
  logic       frame_done;
  logic       busy;
  logic       err;

  int checks;
  int failures;

  // Reference model: full input history plus the cycle of the last flush.
  localparam int HMAX = 16384;
  localparam int MIDLE = 0;
  localparam int MRUN = 1;
  localparam int MDRAIN = 2;
  bit histV [HMAX];
  int t;
  int clrT;
  int mState;
  int mInCnt;
  int mOCnt;

  fft_seq_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_i    (valid_i),
    .bf_sel     (bf_sel),
    .tw_addr1   (tw_addr1),
    .tw_addr2   (tw_addr2),
    .tw_addr3   (tw_addr3),
    .tw_addr4   (tw_addr4),
    .tw_en      (tw_en),
    .valid_o    (valid_o),
    .out_idx    (out_idx),
    .frame_done (frame_done),
    .busy       (busy),
    .err        (err)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int tapL(int k);
    case (k)
      0: return 0;
      1: return 17;
      2: return 26;
      3: return 31;
      default: return 34;
    endcase
  endfunction

  function automatic int delayD(int k);
    return 16 >> k;
  endfunction

  // Was an input sample presented j cycles before cycle tt (since the last flush)?
  function automatic bit sAt(int tt, int j);
    int src;
    src = tt - j;
    if (src < clrT || src < 0) return 1'b0;
    return histV[src];
  endfunction

  function automatic bit aAt(int k, int tt);
    return sAt(tt, tapL(k)) | sAt(tt, tapL(k) + delayD(k));
  endfunction

  // Length of the unbroken active window before cycle tt, modulo 32.
  function automatic int cAt(int k, int tt);
    int n;
    n = 0;
    for (int u = tt - 1; u >= clrT; u--) begin
      if (!aAt(k, u)) break;
      n++;
    end
    return n % 32;
  endfunction

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic checkOutput();
    logic [4:0] eBf;
    logic [3:0] eTw;
    logic [3:0] eAddr [4];
    logic       eVo;
    logic       eFd;
    logic       eBusy;
    logic       eErr;
    logic [4:0] eIdx;
    int         c;
    bit         cb;
    bit         allZero;
    eBf   = 5'd0;
    eTw   = 4'd0;
    eVo   = 1'b0;
    eFd   = 1'b0;
    eBusy = 1'b0;
    eErr  = 1'b0;
    eIdx  = 5'd0;
    for (int k = 0; k < 4; k++) eAddr[k] = 4'd0;
    histV[t] = valid_i;
    if (rst_n) begin
      for (int k = 0; k < 5; k++) begin
        c  = cAt(k, t);
        cb = ((c >> (4 - k)) & 1) == 1;
        eBf[k] = aAt(k, t) & cb;
        if (k < 4) begin
          eTw[k] = sAt(t, tapL(k) + delayD(k)) & ~cb;
          if (eTw[k]) eAddr[k] = 4'(((c % delayD(k)) << k) & 15);
        end
      end
      eVo   = sAt(t, 36);
      eFd   = eVo && (mOCnt == 31);
      eBusy = (mState != MIDLE);
      eErr  = (mState == MRUN) && !valid_i && (mInCnt != 0);
`ifdef FFT_SEQ_CTRL_BITREV_EN
      if (eVo) begin
        for (int b = 0; b < 5; b++) eIdx[b] = 1'((mOCnt >> (4 - b)) & 1);
      end
`endif
    end
    cmp("bf_sel",     {3'b0, bf_sel},     {3'b0, eBf});
    cmp("tw_en",      {4'b0, tw_en},      {4'b0, eTw});
    cmp("tw_addr1",   {4'b0, tw_addr1},   {4'b0, eAddr[0]});
    cmp("tw_addr2",   {4'b0, tw_addr2},   {4'b0, eAddr[1]});
    cmp("tw_addr3",   {4'b0, tw_addr3},   {4'b0, eAddr[2]});
    cmp("tw_addr4",   {4'b0, tw_addr4},   {4'b0, eAddr[3]});
    cmp("valid_o",    {7'b0, valid_o},    {7'b0, eVo});
    cmp("out_idx",    {3'b0, out_idx},    {3'b0, eIdx});
    cmp("frame_done", {7'b0, frame_done}, {7'b0, eFd});
    cmp("busy",       {7'b0, busy},       {7'b0, eBusy});
    cmp("err",        {7'b0, err},        {7'b0, eErr});
    // Advance the model across the coming clock edge.
    if (!rst_n || eErr) begin
      clrT   = t + 1;
      mState = MIDLE;
      mInCnt = 0;
      mOCnt  = 0;
    end else begin
      if (valid_i) mInCnt = (mInCnt + 1) % 32;
      if (eVo) mOCnt = (mOCnt + 1) % 32;
      allZero = 1'b1;
      for (int j = 1; j <= 36; j++) if (sAt(t, j)) allZero = 1'b0;
      case (mState)
        MIDLE:  if (valid_i) mState = MRUN;
        MRUN:   if (!valid_i) mState = MDRAIN;
        default: begin
          if (valid_i) mState = MRUN;
          else if (allZero) mState = MIDLE;
        end
      endcase
    end
    t++;
  endtask

  task automatic applyStimulus(input logic v, input logic r);
    valid_i = v;
    rst_n   = r;
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  task automatic runFrame(input int n, input int gap);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < gap; i++) applyStimulus(1'b0, 1'b1);
  endtask

  int kind;
  int nRst;

  // Directed scenarios followed by randomized frame traffic.
  initial begin
    checks   = 0;
    failures = 0;
    t        = 0;
    clrT     = 0;
    mState   = MIDLE;
    mInCnt   = 0;
    mOCnt    = 0;
    rst_n    = 1'b0;
    valid_i  = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] reset with random valid_i");
    for (int i = 0; i < 4; i++) applyStimulus(1'($urandom_range(0, 1)), 1'b0);

    $display("[TB] single frame");
    runFrame(32, 42);

    $display("[TB] back-to-back frames");
    runFrame(64, 42);

    $display("[TB] mid-frame abort");
    runFrame(11, 6);

    $display("[TB] reset during drain");
    runFrame(32, 8);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    runFrame(0, 40);

    $display("[TB] resume from drain");
    runFrame(32, 5);
    runFrame(32, 45);

    $display("[TB] randomized frames");
    for (int it = 0; it < 24; it++) begin
      kind = int'($urandom_range(0, 9));
      if (kind < 5) begin
        runFrame(32, int'($urandom_range(0, 40)));
      end else if (kind < 7) begin
        runFrame(64, int'($urandom_range(0, 20)));
      end else if (kind < 9) begin
        runFrame(int'($urandom_range(1, 31)), int'($urandom_range(0, 10)));
      end else begin
        runFrame(32, int'($urandom_range(0, 30)));
        nRst = int'($urandom_range(1, 3));
        for (int i = 0; i < nRst; i++) applyStimulus(1'($urandom_range(0, 1)), 1'b0);
      end
    end
    runFrame(0, 45);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
